// File: rtl/mem_bus_responder_pkg.sv
// Shared types, address map and constants for the machine-cycle memory responder.
package mem_bus_responder_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_INT, ST_EXT_WAIT, ST_DONE} state_t;
    typedef enum logic [1:0] {RG_HRAM, RG_IE, RG_UNUSABLE, RG_EXT} region_t;

    localparam int          HRAM_DEPTH     = 127;
    localparam logic [15:0] HRAM_BASE      = 16'hFF80;
    localparam logic [15:0] HRAM_LIMIT     = 16'hFFFE;
    localparam logic [15:0] IE_ADDR        = 16'hFFFF;
    localparam logic [15:0] UNUSABLE_BASE  = 16'hFEA0;
    localparam logic [15:0] UNUSABLE_LIMIT = 16'hFEFF;
    localparam logic [15:0] ECHO_BASE      = 16'hE000;
    localparam logic [15:0] ECHO_LIMIT     = 16'hFDFF;
    localparam logic [15:0] ECHO_OFFSET    = 16'h2000;
    localparam logic [7:0]  OPEN_BUS       = 8'hFF;

    function automatic region_t decode_region(input logic [15:0] addr);
        if (addr == IE_ADDR)
            return RG_IE;
        else if (addr >= HRAM_BASE && addr <= HRAM_LIMIT)
            return RG_HRAM;
        else if (addr >= UNUSABLE_BASE && addr <= UNUSABLE_LIMIT)
            return RG_UNUSABLE;
        else
            return RG_EXT;
    endfunction

    // Echo RAM mirrors WRAM, so the backing store only ever sees WRAM addresses for it.
    function automatic logic [15:0] fold_echo(input logic [15:0] addr);
        if (addr >= ECHO_BASE && addr <= ECHO_LIMIT)
            return addr - ECHO_OFFSET;
        return addr;
    endfunction

endpackage

// File: rtl/mem_bus_responder_hram_array.sv
// 127x8 high RAM: synchronous write, registered read, contents never reset.
module hram_array
    import mem_bus_responder_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic       re,
    input  logic [6:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [0:HRAM_DEPTH-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the four-T-cycle bus: HRAM/IE internal, rest forwarded via req/ack.
// Optional access timeout and sticky bus_err are compiled in with MEM_RESP_TIMEOUT_EN.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  t_cycle,
    input  logic [15:0] addr_bus,
    input  logic        rd,
    input  logic        wr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        hold,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata
`ifdef MEM_RESP_TIMEOUT_EN
    ,
    output logic        bus_err
`endif
);

    state_t      state, next_state;
    region_t     region_in, region_q;
    logic        write_q;
    logic [6:0]  hram_idx_q;
    logic [7:0]  wdata_q;
    logic [7:0]  ie;
    logic [7:0]  hram_q;
    logic        capture;
    logic        abort;
    logic        hram_we;
    logic        ie_we;
    logic        rdata_load;
    logic [7:0]  rdata_next;
    logic        hold_next;

    assign region_in = decode_region(addr_bus);
    assign capture   = (state == ST_IDLE) && (t_cycle == 2'd0) && (rd || wr);
    assign ext_req   = (state == ST_EXT_WAIT);

`ifdef MEM_RESP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // An ack on the final allowed edge still wins over the abort.
    assign abort = (state == ST_EXT_WAIT) && !ext_ack &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            wait_cnt <= (state == ST_EXT_WAIT && next_state == ST_EXT_WAIT) ? wait_cnt + 1'b1 : '0;
            if (abort)
                bus_err <= 1'b1;
        end
    end
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (capture) next_state = (region_in == RG_EXT) ? ST_EXT_WAIT : ST_INT;
            ST_INT:      next_state = ST_DONE;
            ST_EXT_WAIT: if (ext_ack || abort) next_state = ST_DONE;
            ST_DONE:     if (t_cycle == 2'd3) next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        hram_we    = 1'b0;
        ie_we      = 1'b0;
        rdata_load = 1'b0;
        rdata_next = rdata;
        // hold covers every edge after the first one spent waiting for the ack
        hold_next  = (state == ST_EXT_WAIT) && (next_state == ST_EXT_WAIT);
        case (state)
            ST_INT: begin
                if (write_q) begin
                    hram_we = (region_q == RG_HRAM);
                    ie_we   = (region_q == RG_IE);
                end else begin
                    rdata_load = 1'b1;
                    case (region_q)
                        RG_HRAM: rdata_next = hram_q;
                        RG_IE:   rdata_next = ie;
                        default: rdata_next = OPEN_BUS;
                    endcase
                end
            end
            ST_EXT_WAIT: begin
                if (!write_q && ext_ack) begin
                    rdata_load = 1'b1;
                    rdata_next = ext_rdata;
                end else if (!write_q && abort) begin
                    rdata_load = 1'b1;
                    rdata_next = OPEN_BUS;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata     <= OPEN_BUS;
            hold      <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= '0;
            ext_wdata <= '0;
            ie        <= 8'h00;
        end else begin
            hold <= hold_next;
            if (rdata_load)
                rdata <= rdata_next;
            if (ie_we)
                ie <= wdata_q;
            if (capture && region_in == RG_EXT) begin
                ext_we    <= wr;
                ext_addr  <= fold_echo(addr_bus);
                ext_wdata <= wdata;
            end
        end
    end

    // T1 capture; write wins when both strobes are high.
    always_ff @(posedge clk) begin
        if (capture) begin
            write_q    <= wr;
            region_q   <= region_in;
            hram_idx_q <= addr_bus[6:0];
            wdata_q    <= wdata;
        end
    end

    // HRAM is read at the T1 edge so the registered output is ready for the T2 edge.
    hram_array u_hram (
        .clk   (clk),
        .we    (hram_we),
        .waddr (hram_idx_q),
        .wdata (wdata_q),
        .re    (capture && region_in == RG_HRAM),
        .raddr (addr_bus[6:0]),
        .rdata (hram_q)
    );

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: decoder, backing store and reference model.
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  t_cycle;
    logic [15:0] addr_bus;
    logic        rd, wr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        hold, ext_req, ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_ack;
    logic [7:0]  ext_rdata;
`ifdef MEM_RESP_TIMEOUT_EN
    logic        bus_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] store  [0:65535];
    logic [7:0] m_hram [0:126];
    logic [7:0] m_ie;
    logic [7:0] m_rdata;

    always #5 clk = ~clk;

    mem_bus_responder #(.TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .t_cycle   (t_cycle),
        .addr_bus  (addr_bus),
        .rd        (rd),
        .wr        (wr),
        .wdata     (wdata),
        .rdata     (rdata),
        .hold      (hold),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata)
`ifdef MEM_RESP_TIMEOUT_EN
        ,
        .bus_err   (bus_err)
`endif
    );

    // Reference: memory map behaviour, updates model state and says what should be forwarded.
    task automatic model_access(input logic [15:0] a, input logic r, input logic w, input logic [7:0] d,
                                output logic is_ext, output logic [15:0] eaddr);
        is_ext = 1'b0;
        eaddr  = a;
        if (a == 16'hFFFF) begin
            if (w) m_ie = d;
            else if (r) m_rdata = m_ie;
        end else if (a >= 16'hFF80) begin
            if (w) m_hram[a - 16'hFF80] = d;
            else if (r) m_rdata = m_hram[a - 16'hFF80];
        end else if (a >= 16'hFEA0 && a <= 16'hFEFF) begin
            if (!w && r) m_rdata = 8'hFF;
        end else begin
            is_ext = 1'b1;
            if (a >= 16'hE000 && a <= 16'hFDFF) eaddr = a - 16'h2000;
            if (!w && r) m_rdata = store[eaddr];
        end
    endtask

    // One machine cycle: plays the decoder and the backing store. Called and returns at posedge+1.
    // delay = cycle after ext_req rises in which ack is driven (0 = never).
    task automatic run_cycle(input logic [15:0] a, input logic r, input logic w, input logic [7:0] d,
                             input int delay, output logic [7:0] t3_rdata, output int hold_cnt,
                             output int req_cnt, output logic [15:0] seen_addr, output logic seen_we,
                             output logic [7:0] seen_wdata, output logic ok);
        int   req_age;
        logic hold_s;
        logic [1:0] t_pre;
        logic got;
        hold_cnt = 0; req_cnt = 0; req_age = 0; ok = 1'b0; got = 1'b0;
        t3_rdata = 8'h00; seen_addr = 16'h0000; seen_we = 1'b0; seen_wdata = 8'h00;
        t_cycle = 2'd0; addr_bus = a; rd = r; wr = w; wdata = d; ext_ack = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (ext_req) begin
                req_age++;
                if (req_age == 1) begin
                    seen_addr = ext_addr; seen_we = ext_we; seen_wdata = ext_wdata;
                end
                ext_ack   = (req_age == delay);
                ext_rdata = ext_ack ? store[ext_addr] : 8'($urandom);
                if (ext_ack && ext_we) store[ext_addr] = ext_wdata;
            end else begin
                ext_ack   = 1'b0;
            end
            @(negedge clk);
            if (hold) hold_cnt++;
            if (ext_req) req_cnt++;
            if (t_cycle == 2'd2 && !hold && !got) begin
                t3_rdata = rdata;
                got = 1'b1;
            end
            hold_s = hold;
            t_pre  = t_cycle;
            @(posedge clk); #1;
            if (cyc == 0) begin
                rd = 1'b0; wr = 1'b0; addr_bus = 16'($urandom); wdata = 8'($urandom);
            end
            if (t_pre == 2'd3) begin
                t_cycle = 2'd0; ext_ack = 1'b0;
                ok = got;
                break;
            end
            t_cycle = (t_pre == 2'd2 && hold_s) ? 2'd2 : t_cycle + 2'd1;
        end
        ext_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] rv; int hc, rc; logic [15:0] sa; logic sw; logic [7:0] sd; logic ok, ie_ext; logic [15:0] ea;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rdata !== 8'hFF) begin errors++; $display("FAIL reset_rdata: got %h want ff", rdata); end
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b want 0", hold); end
        checks++; if (ext_req !== 1'b0) begin errors++; $display("FAIL reset_ext_req: got %b want 0", ext_req); end
        checks++; if (ext_we !== 1'b0) begin errors++; $display("FAIL reset_ext_we: got %b want 0", ext_we); end
        checks++; if (ext_addr !== 16'h0000) begin errors++; $display("FAIL reset_ext_addr: got %h want 0000", ext_addr); end
        checks++; if (ext_wdata !== 8'h00) begin errors++; $display("FAIL reset_ext_wdata: got %h want 00", ext_wdata); end
`ifdef MEM_RESP_TIMEOUT_EN
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
`endif
        rst = 1'b0;
        model_access(16'hFFFF, 1'b1, 1'b0, 8'h00, ie_ext, ea);
        run_cycle(16'hFFFF, 1'b1, 1'b0, 8'h00, 1, rv, hc, rc, sa, sw, sd, ok);
        checks++; if (!ok || rv !== 8'h00) begin errors++; $display("FAIL reset_ie: got %h ok %b want 00", rv, ok); end
    endtask

    task automatic test_hram();
        logic [7:0] rv; int hc, rc; logic [15:0] sa; logic sw; logic [7:0] sd; logic ok, ie_ext; logic [15:0] ea;
        logic [7:0] d;
        model_access(16'hFF80, 1'b0, 1'b1, 8'h5A, ie_ext, ea);
        run_cycle(16'hFF80, 1'b0, 1'b1, 8'h5A, 1, rv, hc, rc, sa, sw, sd, ok);
        checks++; if (hc !== 0 || rc !== 0) begin errors++; $display("FAIL hram_write_bus: hold %0d req %0d want 0 0", hc, rc); end
        model_access(16'hFF80, 1'b1, 1'b0, 8'h00, ie_ext, ea);
        run_cycle(16'hFF80, 1'b1, 1'b0, 8'h00, 1, rv, hc, rc, sa, sw, sd, ok);
        checks++; if (!ok || rv !== 8'h5A) begin errors++; $display("FAIL hram_read_5a: got %h want 5a", rv); end
        checks++; if (hc !== 0 || rc !== 0) begin errors++; $display("FAIL hram_read_bus: hold %0d req %0d want 0 0", hc, rc); end
        // fill all of HRAM so random reads later have defined contents
        for (int i = 0; i < 127; i++) begin
            d = 8'($urandom);
            model_access(16'hFF80 + 16'(i), 1'b0, 1'b1, d, ie_ext, ea);
            run_cycle(16'hFF80 + 16'(i), 1'b0, 1'b1, d, 1, rv, hc, rc, sa, sw, sd, ok);
            checks++; if (!ok || rv !== m_rdata || rc !== 0) begin
                errors++; $display("FAIL hram_fill[%0d]: rdata %h req %0d want %h 0", i, rv, rc, m_rdata);
            end
        end
    endtask

    task automatic test_echo();
        logic [7:0] rv; int hc, rc; logic [15:0] sa; logic sw; logic [7:0] sd; logic ok, is_ext; logic [15:0] ea;
        model_access(16'hE123, 1'b1, 1'b0, 8'h00, is_ext, ea);
        run_cycle(16'hE123, 1'b1, 1'b0, 8'h00, 1, rv, hc, rc, sa, sw, sd, ok);
        checks++; if (sa !== 16'hC123) begin errors++; $display("FAIL echo_addr: got %h want c123", sa); end
        checks++; if (hc !== 0) begin errors++; $display("FAIL echo_hold: got %0d want 0", hc); end
        checks++; if (!ok || rv !== store[16'hC123]) begin errors++; $display("FAIL echo_rdata: got %h want %h", rv, store[16'hC123]); end
    endtask

    task automatic test_wait_states();
        logic [7:0] rv; int hc, rc; logic [15:0] sa; logic sw; logic [7:0] sd; logic ok, is_ext; logic [15:0] ea;
        model_access(16'h4567, 1'b1, 1'b0, 8'h00, is_ext, ea);
        run_cycle(16'h4567, 1'b1, 1'b0, 8'h00, 5, rv, hc, rc, sa, sw, sd, ok);
        checks++; if (hc !== 4) begin errors++; $display("FAIL wait5_hold: got %0d cycles want 4", hc); end
        checks++; if (!ok || rv !== m_rdata) begin errors++; $display("FAIL wait5_rdata: got %h want %h", rv, m_rdata); end
    endtask

    task automatic test_ie_unusable();
        logic [7:0] rv; int hc, rc; logic [15:0] sa; logic sw; logic [7:0] sd; logic ok, is_ext; logic [15:0] ea;
        model_access(16'hFFFF, 1'b1, 1'b1, 8'h1F, is_ext, ea);
        run_cycle(16'hFFFF, 1'b1, 1'b1, 8'h1F, 1, rv, hc, rc, sa, sw, sd, ok);
        checks++; if (!ok || rv !== m_rdata) begin errors++; $display("FAIL ie_write_holds_rdata: got %h want %h", rv, m_rdata); end
        model_access(16'hFFFF, 1'b1, 1'b0, 8'h00, is_ext, ea);
        run_cycle(16'hFFFF, 1'b1, 1'b0, 8'h00, 1, rv, hc, rc, sa, sw, sd, ok);
        checks++; if (!ok || rv !== 8'h1F) begin errors++; $display("FAIL ie_readback: got %h want 1f", rv); end
        model_access(16'hFEA5, 1'b0, 1'b1, 8'h77, is_ext, ea);
        run_cycle(16'hFEA5, 1'b0, 1'b1, 8'h77, 1, rv, hc, rc, sa, sw, sd, ok);
        checks++; if (rc !== 0) begin errors++; $display("FAIL unusable_write_req: got %0d cycles want 0", rc); end
        model_access(16'hFEA5, 1'b1, 1'b0, 8'h00, is_ext, ea);
        run_cycle(16'hFEA5, 1'b1, 1'b0, 8'h00, 1, rv, hc, rc, sa, sw, sd, ok);
        checks++; if (!ok || rv !== 8'hFF) begin errors++; $display("FAIL unusable_read: got %h want ff", rv); end
    endtask

    task automatic test_random();
        logic [7:0] rv; int hc, rc; logic [15:0] sa; logic sw; logic [7:0] sd; logic ok, is_ext; logic [15:0] ea;
        logic [15:0] a; logic r, w; logic [7:0] d; int delay, mode;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       a = 16'hFF80 + 16'($urandom_range(0, 126));
                1:       a = 16'hFFFF;
                2:       a = 16'hFEA0 + 16'($urandom_range(0, 95));
                3:       a = 16'hE000 + 16'($urandom_range(0, 16'h1DFF));
                default: a = 16'($urandom);
            endcase
            mode  = $urandom_range(0, 2);
            r     = (mode != 1);
            w     = (mode != 0);
            d     = 8'($urandom);
            delay = $urandom_range(1, 4);
            model_access(a, r, w, d, is_ext, ea);
            run_cycle(a, r, w, d, delay, rv, hc, rc, sa, sw, sd, ok);
            checks++; if (!ok || rv !== m_rdata) begin
                errors++; $display("FAIL rand_rdata[%0d] a=%h: got %h want %h", i, a, rv, m_rdata);
            end
            checks++; if (hc !== (is_ext ? delay - 1 : 0) || rc !== (is_ext ? delay : 0)) begin
                errors++; $display("FAIL rand_timing[%0d] a=%h: hold %0d req %0d want %0d %0d", i, a, hc, rc,
                                   is_ext ? delay - 1 : 0, is_ext ? delay : 0);
            end
            if (is_ext) begin
                checks++; if (sa !== ea || sw !== w || (w && sd !== d)) begin
                    errors++; $display("FAIL rand_fwd[%0d]: addr %h we %b data %h want %h %b %h", i, sa, sw, sd, ea, w, d);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rv; int hc, rc; logic [15:0] sa; logic sw; logic [7:0] sd; logic ok, is_ext; logic [15:0] ea;
        model_access(16'h4321, 1'b0, 1'b1, 8'hC6, is_ext, ea);
        run_cycle(16'h4321, 1'b0, 1'b1, 8'hC6, 3, rv, hc, rc, sa, sw, sd, ok);
        model_access(16'h4321, 1'b1, 1'b0, 8'h00, is_ext, ea);
        run_cycle(16'h4321, 1'b1, 1'b0, 8'h00, 2, rv, hc, rc, sa, sw, sd, ok);
        checks++; if (!ok || rv !== 8'hC6) begin errors++; $display("FAIL b2b_ext: got %h want c6", rv); end
        model_access(16'hFFC0, 1'b0, 1'b1, 8'h93, is_ext, ea);
        run_cycle(16'hFFC0, 1'b0, 1'b1, 8'h93, 1, rv, hc, rc, sa, sw, sd, ok);
        model_access(16'hFFC0, 1'b1, 1'b0, 8'h00, is_ext, ea);
        run_cycle(16'hFFC0, 1'b1, 1'b0, 8'h00, 1, rv, hc, rc, sa, sw, sd, ok);
        checks++; if (!ok || rv !== 8'h93) begin errors++; $display("FAIL b2b_hram: got %h want 93", rv); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rv; int hc, rc; logic [15:0] sa; logic sw; logic [7:0] sd; logic ok, is_ext; logic [15:0] ea;
        t_cycle = 2'd0; addr_bus = 16'h1234; rd = 1'b1; wr = 1'b0; ext_ack = 1'b0;
        @(posedge clk); #1;
        rd = 1'b0; t_cycle = 2'd1;
        checks++; if (ext_req !== 1'b1) begin errors++; $display("FAIL mid_req_rise: got %b want 1", ext_req); end
        @(posedge clk); #1;
        t_cycle = 2'd2;
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL mid_hold_rise: got %b want 1", hold); end
        #2 rst = 1'b1;
        #1;
        m_rdata = 8'hFF; m_ie = 8'h00;
        checks++; if (rdata !== 8'hFF || hold !== 1'b0 || ext_req !== 1'b0 || ext_addr !== 16'h0000 || ext_we !== 1'b0) begin
            errors++; $display("FAIL mid_async_reset: rdata %h hold %b req %b addr %h we %b", rdata, hold, ext_req, ext_addr, ext_we);
        end
        @(posedge clk); #1;
        rst = 1'b0; t_cycle = 2'd0; ext_ack = 1'b1; ext_rdata = 8'h3C;
        @(posedge clk); #1;
        ext_ack = 1'b0;
        checks++; if (rdata !== 8'hFF || ext_req !== 1'b0 || hold !== 1'b0) begin
            errors++; $display("FAIL late_ack: rdata %h req %b hold %b want ff 0 0", rdata, ext_req, hold);
        end
        model_access(16'hFFFF, 1'b1, 1'b0, 8'h00, is_ext, ea);
        run_cycle(16'hFFFF, 1'b1, 1'b0, 8'h00, 1, rv, hc, rc, sa, sw, sd, ok);
        checks++; if (!ok || rv !== 8'h00) begin errors++; $display("FAIL after_reset_ie: got %h want 00", rv); end
        model_access(16'hFFC0, 1'b1, 1'b0, 8'h00, is_ext, ea);
        run_cycle(16'hFFC0, 1'b1, 1'b0, 8'h00, 1, rv, hc, rc, sa, sw, sd, ok);
        checks++; if (!ok || rv !== m_rdata) begin errors++; $display("FAIL after_reset_hram: got %h want %h", rv, m_rdata); end
    endtask

`ifdef MEM_RESP_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] rv; int hc, rc; logic [15:0] sa; logic sw; logic [7:0] sd; logic ok;
        run_cycle(16'h2222, 1'b1, 1'b0, 8'h00, 0, rv, hc, rc, sa, sw, sd, ok);
        m_rdata = 8'hFF;
        checks++; if (!ok || rv !== 8'hFF) begin errors++; $display("FAIL timeout_rdata: got %h ok %b want ff", rv, ok); end
        checks++; if (rc !== 8 || hc !== 7) begin errors++; $display("FAIL timeout_len: req %0d hold %0d want 8 7", rc, hc); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL timeout_bus_err: got %b want 1", bus_err); end
        run_cycle(16'hFF81, 1'b1, 1'b0, 8'h00, 1, rv, hc, rc, sa, sw, sd, ok);
        checks++; if (bus_err !== 1'b1 || rv !== m_hram[1]) begin
            errors++; $display("FAIL timeout_sticky: bus_err %b rdata %h want 1 %h", bus_err, rv, m_hram[1]);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; t_cycle = 2'd0; addr_bus = 16'h0000; rd = 1'b0; wr = 1'b0; wdata = 8'h00;
        ext_ack = 1'b0; ext_rdata = 8'h00;
        for (int i = 0; i < 65536; i++) store[i] = 8'($urandom);
        m_ie = 8'h00; m_rdata = 8'hFF;
        test_reset();
        test_hram();
        test_echo();
        test_wait_states();
        test_ie_unusable();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_RESP_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side responder for the CPU's four-T-cycle machine-cycle bus. It captures `addr_bus`, `rd` and `wr` at T1 and serves HRAM (FF80–FFFE) and the IE register (FFFF) internally. It folds echo RAM onto WRAM, forwards everything else to a backing store over a req/ack handshake, and stretches the machine cycle with `hold` when the backing store is slow. It sits between the CPU top level and the external memory model, in place of the direct memory connection.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: maximum clk cycles `ext_req` may wait for `ext_ack`. Used only when the timeout feature is compiled in.

Ports:
- `clk` in 1: single clock; one clk per T-cycle.
- `rst` in 1: asynchronous, active-high reset.
- `t_cycle` in 2: current T-cycle from the decoder. 0 = T1, 3 = T4.
- `addr_bus` in 16: CPU address.
- `rd` in 1: CPU read strobe.
- `wr` in 1: CPU write strobe.
- `wdata` in 8: CPU write data.
- `rdata` out 8: read data to the CPU.
- `hold` out 1: stall request to the decoder; freezes `t_cycle` at 2.
- `ext_req` out 1: backing-store request.
- `ext_we` out 1: backing-store write enable.
- `ext_addr` out 16: backing-store address, after echo folding.
- `ext_wdata` out 8: backing-store write data.
- `ext_ack` in 1: single-cycle completion pulse from the backing store.
- `ext_rdata` in 8: backing-store read data, valid with `ext_ack`.
- `bus_err` out 1: sticky timeout flag. Only present with the timeout feature compiled in.

## Operation
- **Region decode**, on the latched address:
  - FF80–FFFE: HRAM, a 127×8 internal array.
  - FFFF: IE, an 8-bit register.
  - FEA0–FEFF: unusable. Reads return 8'hFF; writes are dropped.
  - E000–FDFF: echo. Forwarded with `ext_addr = addr - 16'h2000`.
  - All other addresses: forwarded unchanged.
- **FSM states:** IDLE, INT, EXT_WAIT, DONE.
  - IDLE → INT or EXT_WAIT on the edge where `t_cycle==0` and (`rd`|`wr`). Address, direction and `wdata` are latched on that edge.
  - INT → DONE after one edge. The HRAM/IE write happens, or `rdata` is loaded.
  - EXT_WAIT → DONE on the edge where `ext_ack` is sampled high. `rdata` is loaded from `ext_rdata` on reads.
  - DONE → IDLE on the edge where `t_cycle==3`.
- **`rd` and `wr` both high at T1:** the write is performed and the read is ignored.
- **Strobes outside T1:** ignored.
- **`ext_req`:** rises on the edge entering EXT_WAIT. `ext_addr`, `ext_we` and `ext_wdata` stay stable while it is high. It drops on the edge that samples `ext_ack`.
- **`ext_ack` when `ext_req` is low:** ignored.
- **`rdata` on writes and unusable-region writes:** holds its last value.
- **Reset values:** `rdata` 8'hFF, `hold` 0, `ext_req` 0, `ext_we` 0, `ext_addr` 0, `ext_wdata` 0, `bus_err` 0, IE 8'h00, FSM IDLE. HRAM contents are not reset.
- **Reset mid-access:** all outputs return to reset values immediately (asynchronous). The pending external access is abandoned, and a late `ext_ack` is ignored.

## Timing
- **Internal read:** `rdata` is valid from the edge ending T2 through the end of T4. No `hold`.
- **Internal write:** takes effect on the edge ending T2.
- **External access, ack sampled on the edge ending T2:** zero wait states; `hold` stays 0.
- **External access, no ack by the edge ending T2:** `hold` goes to 1 on that edge. `t_cycle` then sits at 2.
  - `hold` returns to 0 on the edge that samples `ext_ack`.
  - `rdata` updates on that same edge.
  - T3 resumes next cycle.
- **Hold length:** each extra cycle of ack delay adds exactly one held cycle.
- **Back-to-back machine cycles:** a new T1 capture on the edge after DONE → IDLE is required to work.

## Configuration
- **`MEM_RESP_TIMEOUT_EN` defined:** a counter runs while in EXT_WAIT.
  - When the counter reaches `TIMEOUT_CYCLES`, the access aborts: `ext_req` drops, a read returns 8'hFF, `hold` drops, `bus_err` is set, and the FSM goes to DONE.
  - `bus_err` clears only on `rst`.
- **`MEM_RESP_TIMEOUT_EN` undefined:** no counter and no `bus_err` port. EXT_WAIT waits indefinitely.

## Structure
- **Shared package:** FSM state enum, region base/limit constants (HRAM, IE, unusable, echo), echo offset, and the 8'hFF open-bus value.
- **Sub-module `hram_array`:** 127×8 synchronous-write, registered-read array. Decode, FSM, IE and handshake stay in this module.

## Test plan
- Write 8'h5A to FF80, then read FF80 → `rdata`=8'h5A at T3. `hold` never asserted. `ext_req` never asserted.
- Read E123 with `ext_ack` returned one cycle after `ext_req` → `ext_addr`=C123, zero wait states, `rdata`=`ext_rdata`.
- Read with `ext_ack` delayed 5 cycles → `hold` high for exactly 4 cycles. `t_cycle` frozen at 2. `rdata` correct on release.
- Write 8'h1F to FFFF with `rd` also high → IE=8'h1F. Write to FEA5 → no `ext_req`. Read FEA5 → 8'hFF.
- Assert `rst` during a held external read, then pulse `ext_ack` → all outputs at reset values. The late ack is ignored, and the next T1 access works.
- With `MEM_RESP_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, never ack → `rdata`=8'hFF, `bus_err`=1, `hold` released after 8 cycles.
